// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch stage: owns the PC, registers the ROM word into the IR,
// hands it to the core over valid/ready, redirects on taken jumps, traps out-of-range fetches.
module hack_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_MAX   = 16'd4000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc,
  input  logic [15:0] instruction,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fault_q, fault_d;

  logic        fetch_en;
  logic        take_jump;
  logic        pc_legal;

  // A fetch happens whenever the IR is empty or is being drained this cycle.
  assign fetch_en  = (state_q == ST_RUN) && (!ir_valid_q || ir_ready);
  assign take_jump = (state_q == ST_RUN) && jump && ir_valid_q && ir_ready;
  assign pc_legal  = (pc_q <= PC_MAX);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fetch_en) begin
          if (!pc_legal) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            ir_valid_d = 1'b0;
          end else if (take_jump) begin
            // The sequential word on the ROM bus this cycle is dropped: one bubble.
            pc_d       = jump_addr;
            ir_valid_d = 1'b0;
          end else begin
            ir_d       = instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 16'd1;
          end
        end
      end
      ST_FAULT: begin
        ir_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_hack_fetch.sv
// Bench for hack_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model and a program-order scoreboard.
module tb_hack_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_MAX   = 16'd20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA5A5;
  endfunction

  assign instruction = rom(pc);

  hack_fetch #(.RESET_PC(RESET_PC), .PC_MAX(PC_MAX)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .jump(jump), .jump_addr(jump_addr), .fault(fault)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each cycle must do, from the fetch rules.
  logic        m_live = 1'b0;
  logic        m_boot, m_fault, m_valid;
  logic [15:0] m_pc, m_ir, m_ir_pc;

  always @(posedge clk) begin
    if (reset) begin
      m_live <= 1'b1; m_boot <= 1'b1; m_fault <= 1'b0; m_valid <= 1'b0;
      m_pc <= RESET_PC; m_ir <= 16'h0; m_ir_pc <= 16'h0;
    end else if (m_live) begin
      if (m_boot) m_boot <= 1'b0;
      else if (!m_fault && (!m_valid || ir_ready)) begin
        if (m_pc > PC_MAX) begin
          m_fault <= 1'b1; m_valid <= 1'b0;
        end else if (m_valid && ir_ready && jump) begin
          m_pc <= jump_addr; m_valid <= 1'b0;
        end else begin
          m_ir <= rom(m_pc); m_ir_pc <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 16'd1;
        end
      end
    end
  end

  // Program-order scoreboard: address of the next instruction the core should receive.
  logic [15:0] exp_next = RESET_PC;

  always @(negedge clk) begin
    if (m_live) begin
      check("pc", pc, m_pc);
      check("ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
      check("fault", {15'd0, fault}, {15'd0, m_fault});
      if (m_valid) begin
        check("ir", ir, m_ir);
        check("ir_pc", ir_pc, m_ir_pc);
      end
      if (reset) exp_next <= RESET_PC;
      else if (ir_valid && ir_ready) begin
        check("order_pc", ir_pc, exp_next);
        check("order_word", ir, rom(ir_pc));
        exp_next <= jump ? jump_addr : ir_pc + 16'd1;
      end
    end
  end

  task automatic drive(input logic r, input logic rdy, input logic j, input logic [15:0] ja);
    reset = r; ir_ready = rdy; jump = j; jump_addr = ja;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset, then first word two edges later, A..D stream
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    check("rst_valid", {15'd0, ir_valid}, 16'd0);
    check("rst_pc", pc, 16'd0);
    drive(0, 1, 0, 0);
    check("boot_valid", {15'd0, ir_valid}, 16'd0);
    check("boot_pc", pc, 16'd0);
    drive(0, 1, 0, 0);
    check("first_valid", {15'd0, ir_valid}, 16'd1);
    check("first_ir", ir, 16'hA5A5);
    check("first_ir_pc", ir_pc, 16'd0);
    drive(0, 1, 0, 0);
    check("second_ir", ir, 16'hA5A6);
    // Stall on B for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      check("stall_ir_pc", ir_pc, 16'd1);
      check("stall_pc", pc, 16'd2);
      check("stall_ir", ir, 16'hA5A6);
    end
    drive(0, 1, 0, 0);
    check("after_stall_ir", ir, 16'hA5A3);
    check("after_stall_ir_pc", ir_pc, 16'd2);
    // Jump taken on ir_pc=2 to 10
    drive(0, 1, 1, 16'd10);
    check("bubble_valid", {15'd0, ir_valid}, 16'd0);
    check("bubble_pc", pc, 16'd10);
    drive(0, 1, 0, 0);
    check("target_ir", ir, 16'hA5BB);
    check("target_ir_pc", ir_pc, 16'd10);
    // Jump without handshake is ignored
    drive(0, 0, 1, 16'd5);
    check("nojump_ir_pc", ir_pc, 16'd10);
    check("nojump_pc", pc, 16'd11);
    drive(0, 1, 0, 0);
    check("seq_ir_pc", ir_pc, 16'd11);
    drive(0, 1, 1, 16'd0);
    drive(0, 1, 1, 16'd7);
    check("bubble_jump_ignored", ir_pc, 16'd0);
    // Straight run into the trap
    n = 0;
    while (!fault && n < 60) begin
      drive(0, 1, 0, 0);
      n++;
    end
    check("trap_fault", {15'd0, fault}, 16'd1);
    check("trap_valid", {15'd0, ir_valid}, 16'd0);
    check("trap_pc", pc, PC_MAX + 16'd1);
    drive(0, 1, 1, 16'd3);
    drive(0, 1, 1, 16'd3);
    check("frozen_pc", pc, PC_MAX + 16'd1);
    check("frozen_fault", {15'd0, fault}, 16'd1);
    // Reset during FAULT
    drive(1, 1, 0, 0);
    check("rf_pc", pc, 16'd0);
    check("rf_ir", ir, 16'd0);
    check("rf_ir_pc", ir_pc, 16'd0);
    check("rf_fault", {15'd0, fault}, 16'd0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("restart_ir_pc", ir_pc, 16'd0);
    // Out-of-range jump target faults on its own fetch
    drive(0, 1, 1, 16'd9000);
    check("far_bubble_fault", {15'd0, fault}, 16'd0);
    drive(0, 1, 0, 0);
    check("far_fault", {15'd0, fault}, 16'd1);
    check("far_pc", pc, 16'd9000);
    // Reset mid-stall
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("rs_valid", {15'd0, ir_valid}, 16'd0);
    check("rs_ir", ir, 16'd0);
    check("rs_pc", pc, 16'd0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, int'(PC_MAX) + 3));
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, ja);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
